cop0_intr_ctrl: RTL and testbench

Coprocessor-0 exception/interrupt sequencer for the single-cycle MIPS core. It arbitrates between SYSCALL and NUM_IRQ external interrupt requests and redirects the PC to the exception vector. It saves EPC, holds the Status/Cause/EPC registers and returns from the handler on ERET. It sits beside the PC-select mux and is driven by decode outputs (IsSyscall, IsCOP0-derived MTC0/MFC0/ERET strobes).

---
 rtl/cop0_intr_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_cop0_intr_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cop0_intr_ctrl.sv
// ---------------------------------------------------------------------------
// cop0_intr_ctrl
// Coprocessor-0 exception/interrupt sequencer for the single-cycle MIPS core.
// It arbitrates SYSCALL against NUM_IRQ edge-captured interrupt requests,
// redirects the PC to the exception vector, saves EPC and returns on ERET.
// It holds Status (12), Cause (13) and EPC (14).
//
// Ports:
//   Clk, Reset_n          rising-edge clock, async active-low reset
//   IrqReq[NUM_IRQ]       interrupt request levels (Clk-synchronous)
//   InstrValid            an instruction retires this cycle
//   IsSyscall, IsEret     decoded SYSCALL / ERET
//   PcCurrent, PcNext     PC of the current instruction / normal next PC
//   MtcWe/MtcAddr/MtcData MTC0 write port
//   MfcAddr/MfcData       MFC0 read port (combinational, pre-edge value)
//   PcRedirect/PcTarget   PC override for this cycle (combinational)
//   InService             handler active (Status.EXL)
//   IrqClear[NUM_IRQ]     one-cycle acknowledge of the taken IRQ (registered)
// ---------------------------------------------------------------------------
module cop0_intr_ctrl #(
    parameter int          NUM_IRQ    = 3,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_3000
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [NUM_IRQ-1:0] IrqReq,
    input  logic               InstrValid,
    input  logic               IsSyscall,
    input  logic               IsEret,
    input  logic [31:0]        PcCurrent,
    input  logic [31:0]        PcNext,
    input  logic               MtcWe,
    input  logic [4:0]         MtcAddr,
    input  logic [31:0]        MtcData,
    input  logic [4:0]         MfcAddr,
    output logic [31:0]        MfcData,
    output logic               PcRedirect,
    output logic [31:0]        PcTarget,
    output logic               InService,
    output logic [NUM_IRQ-1:0] IrqClear
);

    localparam logic [4:0] ADDR_STATUS = 5'd12;
    localparam logic [4:0] ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] ADDR_EPC    = 5'd14;
    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_SYS     = 5'd8;

    // The FSM state is Status.EXL itself: RUN when clear, HANDLER when set.
    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_HANDLER = 1'b1
    } state_t;

    state_t               state_r;
    logic                 ie_r;
    logic [NUM_IRQ-1:0]   im_r;
    logic [4:0]           exc_code_r;
    logic [NUM_IRQ-1:0]   pending_r;
    logic [NUM_IRQ-1:0]   hist_r;
    logic [31:0]          epc_r;
    logic [NUM_IRQ-1:0]   irq_clear_r;

    logic [NUM_IRQ-1:0]   edge_s;
    logic [NUM_IRQ-1:0]   irq_mask_s;
    logic [NUM_IRQ-1:0]   irq_sel_s;
    logic                 eret_act_s;
    logic                 sys_act_s;
    logic                 take_s;
    logic                 wr_status_s;
    logic                 wr_epc_s;
    logic [31:0]          status_word_s;
    logic [31:0]          cause_word_s;

    // Event decode: ERET beats SYSCALL, SYSCALL beats interrupts, and the
    // winning interrupt is the lowest-index enabled pending line.
    always_comb begin
        edge_s      = IrqReq & ~hist_r;
        irq_mask_s  = pending_r & im_r;
        irq_sel_s   = irq_mask_s & (~irq_mask_s + NUM_IRQ'(1));
        eret_act_s  = InstrValid & IsEret;
        sys_act_s   = InstrValid & IsSyscall & ~IsEret;
        wr_status_s = MtcWe & (MtcAddr == ADDR_STATUS);
        wr_epc_s    = MtcWe & (MtcAddr == ADDR_EPC);
        if (InstrValid && (state_r == ST_RUN) && !IsEret && !IsSyscall
            && ie_r && (|irq_mask_s)) begin
            take_s = 1'b1;
        end else begin
            take_s = 1'b0;
        end
    end

    // PC redirect: ERET returns to EPC, any exception goes to the vector.
    always_comb begin
        PcRedirect = eret_act_s | sys_act_s | take_s;
        if (eret_act_s) begin
            PcTarget = epc_r;
        end else if (sys_act_s || take_s) begin
            PcTarget = EXC_VECTOR;
        end else begin
            PcTarget = 32'h0000_0000;
        end
    end

    // MFC0 read mux; unimplemented registers and bits read as zero.
    always_comb begin
        status_word_s                  = 32'h0000_0000;
        status_word_s[0]               = ie_r;
        status_word_s[1]               = state_r;
        status_word_s[8 +: NUM_IRQ]    = im_r;
        cause_word_s                   = 32'h0000_0000;
        cause_word_s[6:2]              = exc_code_r;
        cause_word_s[8 +: NUM_IRQ]     = pending_r;
        case (MfcAddr)
            ADDR_STATUS: MfcData = status_word_s;
            ADDR_CAUSE:  MfcData = cause_word_s;
            ADDR_EPC:    MfcData = epc_r;
            default:     MfcData = 32'h0000_0000;
        endcase
    end

    assign InService = state_r;
    assign IrqClear  = irq_clear_r;

    // Status register and FSM state; exception entry/exit override an MTC0
    // write of EXL, while IE/IM still follow the write.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= ST_RUN;
            ie_r    <= 1'b0;
            im_r    <= '0;
        end else begin
            if (wr_status_s) begin
                ie_r    <= MtcData[0];
                im_r    <= MtcData[8 +: NUM_IRQ];
                state_r <= state_t'(MtcData[1]);
            end
            if (take_s || sys_act_s) begin
                state_r <= ST_HANDLER;
            end else if (eret_act_s && (state_r == ST_HANDLER)) begin
                state_r <= ST_RUN;
            end
        end
    end

    // EPC and ExcCode; a SYSCALL inside the handler keeps the original EPC.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            epc_r      <= 32'h0000_0000;
            exc_code_r <= 5'd0;
        end else begin
            if (take_s) begin
                epc_r      <= PcNext;
                exc_code_r <= EXC_INT;
            end else if (sys_act_s) begin
                exc_code_r <= EXC_SYS;
                if (state_r == ST_RUN) begin
                    epc_r <= PcCurrent;
                end else if (wr_epc_s) begin
                    epc_r <= MtcData;
                end
            end else if (wr_epc_s) begin
                epc_r <= MtcData;
            end
        end
    end

    // Edge capture into pending; a new edge wins over the clear on take.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hist_r      <= '0;
            pending_r   <= '0;
            irq_clear_r <= '0;
        end else begin
            hist_r      <= IrqReq;
            pending_r   <= (pending_r & ~(take_s ? irq_sel_s : '0)) | edge_s;
            irq_clear_r <= take_s ? irq_sel_s : '0;
        end
    end

endmodule

// File: tb/tb_cop0_intr_ctrl.sv
module tb_cop0_intr_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  irq_req;
    logic        instr_valid, is_syscall, is_eret, mtc_we;
    logic [31:0] pc_current, pc_next, mtc_data;
    logic [4:0]  mtc_addr, mfc_addr;
    logic [31:0] mfc_data, pc_target;
    logic        pc_redirect, in_service;
    logic [2:0]  irq_clear;

    int total = 0;
    int bad   = 0;

    cop0_intr_ctrl #(.NUM_IRQ(3), .EXC_VECTOR(32'h0000_3000)) dut (
        .Clk(clk), .Reset_n(rst_n), .IrqReq(irq_req), .InstrValid(instr_valid),
        .IsSyscall(is_syscall), .IsEret(is_eret), .PcCurrent(pc_current),
        .PcNext(pc_next), .MtcWe(mtc_we), .MtcAddr(mtc_addr), .MtcData(mtc_data),
        .MfcAddr(mfc_addr), .MfcData(mfc_data), .PcRedirect(pc_redirect),
        .PcTarget(pc_target), .InService(in_service), .IrqClear(irq_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        mfc_addr = addr;
        #1;
        chk(tag, mfc_data, exp);
    endtask

    // Advance to just after the next rising edge and return inputs to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        instr_valid = 1'b0; is_syscall = 1'b0; is_eret = 1'b0; mtc_we = 1'b0;
        mtc_addr = 5'd0; mtc_data = 32'h0; pc_current = 32'h0; pc_next = 32'h0;
    endtask

    task automatic mtc(input logic [4:0] addr, input logic [31:0] data);
        mtc_we = 1'b1; mtc_addr = addr; mtc_data = data;
    endtask

    initial begin
        rst_n = 1'b0; irq_req = 3'b000; mfc_addr = 5'd0;
        instr_valid = 1'b0; is_syscall = 1'b0; is_eret = 1'b0; mtc_we = 1'b0;
        mtc_addr = 5'd0; mtc_data = 32'h0; pc_current = 32'h0; pc_next = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        rd("rst_status", 5'd12, 32'h0);
        rd("rst_cause", 5'd13, 32'h0);
        rd("rst_epc", 5'd14, 32'h0);
        chk("rst_redirect", {31'd0, pc_redirect}, 32'd0);
        chk("rst_inservice", {31'd0, in_service}, 32'd0);
        chk("rst_irqclear", {29'd0, irq_clear}, 32'd0);

        // SYSCALL from RUN
        tick();
        instr_valid = 1'b1; is_syscall = 1'b1; pc_current = 32'h0000_0040;
        #1;
        chk("sys_redirect", {31'd0, pc_redirect}, 32'd1);
        chk("sys_target", pc_target, 32'h0000_3000);
        tick();
        rd("sys_epc", 5'd14, 32'h0000_0040);
        rd("sys_cause", 5'd13, 32'h0000_0020);
        chk("sys_inservice", {31'd0, in_service}, 32'd1);

        // ERET back to RUN
        tick();
        instr_valid = 1'b1; is_eret = 1'b1;
        #1;
        chk("eret1_target", pc_target, 32'h0000_0040);
        tick();
        chk("eret1_inservice", {31'd0, in_service}, 32'd0);

        // Interrupt priority: lines 1 and 2 rise together
        mtc(5'd12, 32'h0000_0701);
        tick();
        irq_req = 3'b110;
        tick();
        instr_valid = 1'b1; pc_next = 32'h0000_0088;
        #1;
        chk("irq_redirect", {31'd0, pc_redirect}, 32'd1);
        chk("irq_target", pc_target, 32'h0000_3000);
        tick();
        chk("irq_clear_pulse", {29'd0, irq_clear}, 32'h2);
        rd("irq_epc", 5'd14, 32'h0000_0088);
        rd("irq_cause", 5'd13, 32'h0000_0400);
        chk("irq_inservice", {31'd0, in_service}, 32'd1);
        instr_valid = 1'b1;
        #1;
        chk("handler_no_take", {31'd0, pc_redirect}, 32'd0);
        tick();
        chk("irq_clear_one_cycle", {29'd0, irq_clear}, 32'h0);

        // ERET from HANDLER, then pending IRQ2 is taken
        instr_valid = 1'b1; is_eret = 1'b1;
        #1;
        chk("eret2_target", pc_target, 32'h0000_0088);
        chk("eret2_redirect", {31'd0, pc_redirect}, 32'd1);
        tick();
        chk("eret2_inservice", {31'd0, in_service}, 32'd0);
        instr_valid = 1'b1; pc_next = 32'h0000_0100;
        #1;
        chk("irq2_redirect", {31'd0, pc_redirect}, 32'd1);
        tick();
        chk("irq2_clear", {29'd0, irq_clear}, 32'h4);
        rd("irq2_epc", 5'd14, 32'h0000_0100);

        // Masking: IM=0, then IE=0, then both enabled
        mtc(5'd12, 32'h0000_0001);
        irq_req = 3'b111;
        tick();
        tick();
        instr_valid = 1'b1;
        #1;
        chk("mask_im0", {31'd0, pc_redirect}, 32'd0);
        tick();
        mtc(5'd12, 32'h0000_0100);
        tick();
        instr_valid = 1'b1;
        #1;
        chk("mask_ie0", {31'd0, pc_redirect}, 32'd0);
        tick();
        mtc(5'd12, 32'h0000_0101);
        tick();
        #1;
        chk("stall_no_take", {31'd0, pc_redirect}, 32'd0);
        tick();
        instr_valid = 1'b1; pc_next = 32'h0000_0200;
        #1;
        chk("unmask_take", {31'd0, pc_redirect}, 32'd1);
        tick();
        chk("unmask_clear", {29'd0, irq_clear}, 32'h1);
        rd("unmask_epc", 5'd14, 32'h0000_0200);

        // SYSCALL and IRQ in the same cycle
        mtc(5'd12, 32'h0000_0101);
        irq_req = 3'b110;
        tick();
        irq_req = 3'b111;
        tick();
        instr_valid = 1'b1; is_syscall = 1'b1; pc_current = 32'h0000_0300; pc_next = 32'h0000_0304;
        #1;
        chk("sysirq_target", pc_target, 32'h0000_3000);
        tick();
        rd("sysirq_cause", 5'd13, 32'h0000_0120);
        rd("sysirq_epc", 5'd14, 32'h0000_0300);
        chk("sysirq_noclear", {29'd0, irq_clear}, 32'h0);

        // Cause is read-only, EPC writable, unused address reads zero
        mtc(5'd13, 32'hFFFF_FFFF);
        tick();
        rd("cause_ro", 5'd13, 32'h0000_0120);
        mtc(5'd14, 32'h0000_1234);
        tick();
        rd("epc_write", 5'd14, 32'h0000_1234);
        rd("unused_addr", 5'd5, 32'h0);

        // ERET and SYSCALL together: ERET wins
        instr_valid = 1'b1; is_eret = 1'b1; is_syscall = 1'b1;
        #1;
        chk("eretsys_target", pc_target, 32'h0000_1234);
        tick();
        chk("eretsys_inservice", {31'd0, in_service}, 32'd0);

        // Take pending IRQ0, then reset inside the handler
        instr_valid = 1'b1; pc_next = 32'h0000_0400;
        tick();
        chk("pre_reset_inservice", {31'd0, in_service}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_inservice", {31'd0, in_service}, 32'd0);
        chk("mid_reset_irqclear", {29'd0, irq_clear}, 32'h0);
        rd("mid_reset_epc", 5'd14, 32'h0);
        rd("mid_reset_status", 5'd12, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
